inst_axi_bridge: RTL and testbench
==================================

# inst_axi_bridge

Instruction-side read bridge that converts the fetch stage's SRAM-like request/addr_ok/data_ok interface into single-beat AXI4 read transactions. It sits directly upstream of the fetch stage: it accepts fetch addresses, issues them on the AR channel, and returns R data as `inst_sram_rdata` with a one-cycle `inst_sram_data_ok` pulse. It is read-only and instruction-only. The AXI ID is fixed at 0.

## Interface
Parameters:
- `AXI_ID`, default 4'd0: constant driven on `arid` and expected on `rid`.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `inst_sram_req`  in  1  fetch request
- `inst_sram_wr`  in  1  write flag; requests with `wr`=1 are never accepted
- `inst_sram_size`  in  2  log2 of the byte count
- `inst_sram_addr`  in  32  physical fetch address
- `inst_sram_wstrb`  in  4  ignored
- `inst_sram_wdata`  in  32  ignored
- `inst_sram_addr_ok`  out  1  request accepted this cycle
- `inst_sram_data_ok`  out  1  `rdata` valid this cycle (one-cycle pulse)
- `inst_sram_rdata`  out  32  returned instruction
- `arid`  out  4  = `AXI_ID`
- `araddr`  out  32  latched address
- `arlen`  out  8  = 0
- `arsize`  out  3  = {1'b0, size}
- `arburst`  out  2  = 2'b01
- `arlock`  out  2  = 0
- `arcache`  out  4  = 0
- `arprot`  out  3  = 0
- `arvalid`  out  1  AR valid
- `arready`  in  1  AR ready
- `rid`  in  4  R ID
- `rdata`  in  32  R data
- `rresp`  in  2  ignored
- `rlast`  in  1  always 1 for single-beat reads
- `rvalid`  in  1  R valid
- `rready`  out  1  R ready

## Operation
AR state machine:
- States: `AR_IDLE`, `AR_SEND`.
- `addr_ok` = `resetn` & `req` & ~`wr` & (state==`AR_IDLE`) & ~`full`. It is combinational.
- On `addr_ok`, the bridge latches `addr` into `araddr` and `size` into `arsize`, then moves to `AR_SEND`.
- In `AR_SEND`, `arvalid`=1 and `araddr`/`arsize` stay stable. On `arvalid`&`arready` the state returns to `AR_IDLE`.
- No new request is accepted while in `AR_SEND`.

Outstanding counter `out_cnt` (2 bits):
- +1 on `addr_ok`.
- −1 on R handshake (`rvalid`&`rready`&`rlast`).
- When both events occur in the same cycle, the count is unchanged.
- `full` = (`out_cnt` == `MAX_OUT`). `full` uses the current `out_cnt` only; an R handshake in the same cycle does not bypass it.

R path:
- `rready` = `resetn` & ~`data_ok_r`.
- On R handshake, `rdata` is registered into `rdata_r` and `data_ok_r` is set for exactly one cycle.
- `inst_sram_data_ok` = `data_ok_r`.
- `inst_sram_rdata` = `rdata_r`. `rdata_r` holds its value until the next R handshake.
- The fetch stage must consume data in the `data_ok` cycle; it buffers internally.
- Data returns in AR issue order.
- `rresp` errors are not reported.
- `rid`≠`AXI_ID` is a protocol violation. It is flagged by simulation assertion only.

Reset (`resetn`=0 at a clock edge):
- State returns to `AR_IDLE`.
- `arvalid`=0, `out_cnt`=0, `data_ok_r`=0, `rdata_r`=0, `araddr`=0, `arsize`=0.
- `addr_ok`=0 and `rready`=0 while reset is asserted.
- Reset mid-transaction drops all tracking. In-flight R beats are the interconnect's responsibility; the bridge is reset together with the AXI slave.

## Timing
- `addr_ok` is combinational in the request cycle N. `arvalid` rises at N+1.
- `arvalid` stays high until `arready` is sampled high. `AR_IDLE` is re-entered the cycle after the handshake.
- R handshake in cycle M gives `data_ok`=1 in cycle M+1.
- `rready` is low during the `data_ok` cycle, so back-to-back R beats are accepted at most every second cycle.
- Minimum request-to-data latency (arready=1, rvalid in the cycle after the AR handshake):
  - addr_ok at N
  - AR handshake at N+1
  - R handshake at N+2
  - data_ok at N+3
- Maximum acceptance rate is one request every 2 cycles (`AR_IDLE`/`AR_SEND` alternation).

## Configuration
- `INST_BRIDGE_OUTSTANDING2_EN` defined: `MAX_OUT`=2. A second address may be issued before the first read's data returns.
- `INST_BRIDGE_OUTSTANDING2_EN` undefined: `MAX_OUT`=1. `addr_ok` is blocked from the first `addr_ok` until the R handshake of that read.

## Structure
- Shared package/header holds:
  - the AXI constants (burst INCR, lock/cache/prot zero)
  - `MAX_OUT`
  - the AR state encoding
- Flat module, no sub-modules.

## Test plan
- Single fetch: `req`=1, `addr`=0x1c000000, `arready`=1; `rdata`=0x02800c0c returned 1 cycle after the AR handshake → `addr_ok` at cycle 0, `araddr`=0x1c000000 with `arsize`=3'b010 and `arvalid` at cycle 1, `data_ok`=1 with `rdata`=0x02800c0c at cycle 3.
- AR backpressure: `arready`=0 for 4 cycles → `arvalid` and `araddr` stable for 5 cycles; `addr_ok`=0 throughout, even with a new `req` and `addr`=0x1c000004 presented.
- Outstanding limit, macro on: two requests with R withheld → both accepted; third `addr_ok`=0 until the first R handshake. Macro off: the second is blocked until the first R handshake.
- Back-to-back R: `rvalid` held high with 0x11111111 then 0x22222222 → `rready` low in each `data_ok` cycle; `data_ok` pulses in two non-adjacent cycles, returning the values in order.
- Write rejection: `req`=1, `wr`=1 → `addr_ok`=0 and `arvalid` never rises.
- Reset mid-read: `resetn`=0 while in `AR_SEND` with `out_cnt`=1 → next cycle `arvalid`=0, `out_cnt`=0, `data_ok`=0; a request after release is accepted immediately.

Source files
------------

// File: rtl/inst_axi_bridge_pkg.sv
// inst_axi_bridge_pkg: shared AXI constants, outstanding limit and AR state encoding. Rev 1.0
// Build option: INST_BRIDGE_OUTSTANDING2_EN raises the outstanding-read limit from 1 to 2.
`default_nettype none

package inst_axi_bridge_pkg;

  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

`ifdef INST_BRIDGE_OUTSTANDING2_EN
  localparam logic [1:0] MAX_OUT = 2'd2;
`else
  localparam logic [1:0] MAX_OUT = 2'd1;
`endif

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: fetch-side SRAM-like request/addr_ok/data_ok to single-beat AXI4 read bridge. Rev 1.0
// Build option: INST_BRIDGE_OUTSTANDING2_EN allows two reads in flight (default build: one).
`default_nettype none

module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  ar_state_t   state;
  logic [1:0]  out_cnt;
  logic        data_ok_r;
  logic [31:0] rdata_r;
  logic        full;
  logic        addr_ok;
  logic        r_hs;
  logic        unused_ok;

  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  // full looks only at the registered count; a same-cycle R beat does not free a slot early
  assign full    = (out_cnt == MAX_OUT);
  assign addr_ok = resetn & inst_sram_req & ~inst_sram_wr & (state == AR_IDLE) & ~full;
  assign rready  = resetn & ~data_ok_r;
  assign r_hs    = rvalid & rready & rlast;

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = data_ok_r;
  assign inst_sram_rdata   = rdata_r;

  assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rresp, rid};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= AR_IDLE;
      arvalid   <= 1'b0;
      araddr    <= 32'd0;
      arsize    <= 3'd0;
      out_cnt   <= 2'd0;
      data_ok_r <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      data_ok_r <= r_hs;
      if (r_hs) begin
        rdata_r <= rdata;
      end

      case ({addr_ok, r_hs})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase

      case (state)
        AR_IDLE: begin
          if (addr_ok) begin
            araddr  <= inst_sram_addr;
            arsize  <= {1'b0, inst_sram_size};
            arvalid <= 1'b1;
            state   <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= AR_IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          state   <= AR_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn && rvalid && rready) begin
      assert (rid == AXI_ID)
        else $error("inst_axi_bridge: unexpected rid %0h", rid);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed and randomized checks of inst_axi_bridge against a transaction-level model.
`default_nettype none

module tb_inst_axi_bridge;

`ifdef INST_BRIDGE_OUTSTANDING2_EN
  localparam int MAXO = 2;
`else
  localparam int MAXO = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: in-flight reads, pending AR, returned data
  bit          m_send;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  int          m_out;
  bit          m_dok;
  logic [31:0] m_rdata;
  logic [31:0] slq[$];
  logic [31:0] ovr[$];
  logic [31:0] dq[$];
  int          dcyc[$];
  bit          rv_en;
  int          cyc_n = 0;
  int          acc;

  inst_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_addr(addr), .inst_sram_wstrb(wstrb), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic slave_drive();
    if (rv_en && slq.size() > 0) begin
      rvalid = 1'b1;
      rdata  = slq[0];
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
  endtask

  task automatic cyc();
    bit aok, rr, arhs, rhs;
    #1;
    aok = resetn && req && !wr && !m_send && (m_out < MAXO);
    rr  = resetn && !m_dok;
    chk("addr_ok", {31'd0, addr_ok}, {31'd0, aok});
    chk("rready", {31'd0, rready}, {31'd0, rr});
    chk("arvalid", {31'd0, arvalid}, {31'd0, m_send});
    chk("araddr", araddr, m_araddr);
    chk("arsize", {29'd0, arsize}, {29'd0, m_arsize});
    chk("data_ok", {31'd0, data_ok}, {31'd0, m_dok});
    chk("rdata", sram_rdata, m_rdata);
    if (m_dok) begin
      dq.push_back(m_rdata);
      dcyc.push_back(cyc_n);
    end
    arhs = m_send && arready;
    rhs  = rvalid && rr && rlast;
    @(posedge clk);
    cyc_n++;
    if (!resetn) begin
      m_send = 0; m_araddr = '0; m_arsize = '0; m_out = 0; m_dok = 0; m_rdata = '0;
      slq.delete();
    end else begin
      m_dok = rhs;
      if (rhs) begin
        m_rdata = rdata;
        if (slq.size() > 0) void'(slq.pop_front());
      end
      if (arhs) begin
        if (ovr.size() > 0) slq.push_back(ovr.pop_front());
        else slq.push_back(mem_word(m_araddr));
      end
      m_out = m_out + int'(aok) - int'(rhs);
      if (aok) begin
        m_send = 1; m_araddr = addr; m_arsize = {1'b0, size};
      end else if (arhs) begin
        m_send = 0;
      end
    end
    #1;
  endtask

  task automatic step();
    slave_drive();
    cyc();
  endtask

  initial begin
    resetn = 0; req = 1; wr = 0; size = 2'd2; addr = 32'h1c00_0000;
    wstrb = '0; wdata = '0; arready = 0; rid = 4'd0; rresp = 2'd0; rlast = 1'b1;
    rvalid = 0; rdata = '0; rv_en = 0;
    @(posedge clk); @(posedge clk); #1;
    m_send = 0; m_araddr = '0; m_arsize = '0; m_out = 0; m_dok = 0; m_rdata = '0;

    // reset state, requests ignored
    step(); step();
    chk("arid", {28'd0, arid}, 32'd0);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arlock", {30'd0, arlock}, 32'd0);
    chk("arcache", {28'd0, arcache}, 32'd0);
    chk("arprot", {29'd0, arprot}, 32'd0);
    req = 0; resetn = 1;
    step();

    // single fetch at minimum latency
    ovr.push_back(32'h0280_0c0c); rv_en = 1; arready = 1;
    req = 1; addr = 32'h1c00_0000; size = 2'd2;
    slave_drive(); #1;
    chk("sf_addr_ok_c0", {31'd0, addr_ok}, 32'd1);
    cyc();
    chk("sf_arvalid_c1", {31'd0, arvalid}, 32'd1);
    chk("sf_araddr_c1", araddr, 32'h1c00_0000);
    chk("sf_arsize_c1", {29'd0, arsize}, 32'd2);
    req = 0;
    step(); step();
    chk("sf_data_ok_c3", {31'd0, data_ok}, 32'd1);
    chk("sf_rdata_c3", sram_rdata, 32'h0280_0c0c);
    step(); step();

    // AR backpressure with a competing request
    arready = 0; req = 1; addr = 32'h1c00_0008;
    step();
    addr = 32'h1c00_0004;
    for (int i = 0; i < 4; i++) begin
      chk("bp_araddr", araddr, 32'h1c00_0008);
      slave_drive(); #1;
      chk("bp_addr_ok", {31'd0, addr_ok}, 32'd0);
      cyc();
    end
    arready = 1;
    chk("bp_arvalid_last", {31'd0, arvalid}, 32'd1);
    chk("bp_araddr_last", araddr, 32'h1c00_0008);
    step();
    req = 0;
    for (int i = 0; i < 4; i++) step();

    // outstanding limit with R withheld
    ovr.delete(); ovr.push_back(32'h1111_1111); ovr.push_back(32'h2222_2222);
    rv_en = 0; arready = 1; req = 1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      addr = 32'h1c00_0100 + 32'(4 * i);
      slave_drive(); #1;
      if (addr_ok) acc++;
      cyc();
    end
    chk("ol_accepts", acc, MAXO);
    dq.delete(); dcyc.delete();
    rv_en = 1; addr = 32'h1c00_0200;
    slave_drive(); #1;
    chk("ol_full_on_rhs", {31'd0, addr_ok}, 32'd0);
    cyc();
    slave_drive(); #1;
    chk("ol_freed", {31'd0, addr_ok}, 32'd1);
    cyc();

    // back-to-back R beats with rvalid held
    req = 0;
    for (int i = 0; i < 10; i++) step();
    chk("b2b_count", {31'd0, dq.size() >= 2}, 32'd1);
    if (dq.size() >= 2) begin
      chk("b2b_first", dq[0], 32'h1111_1111);
      chk("b2b_second", dq[1], 32'h2222_2222);
      chk("b2b_gap", {31'd0, (dcyc[1] - dcyc[0]) >= 2}, 32'd1);
    end

    // write requests are never accepted
    req = 1; wr = 1; addr = 32'h1c00_0300;
    for (int i = 0; i < 4; i++) begin
      slave_drive(); #1;
      chk("wr_addr_ok", {31'd0, addr_ok}, 32'd0);
      cyc();
      chk("wr_arvalid", {31'd0, arvalid}, 32'd0);
    end
    wr = 0; req = 0;
    step();

    // reset during AR_SEND with one read outstanding
    arready = 0; rv_en = 0; req = 1; addr = 32'h1c00_0400;
    step();
    req = 0;
    step();
    resetn = 0;
    step();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    resetn = 1; req = 1; addr = 32'h1c00_0500;
    slave_drive(); #1;
    chk("rst_accept", {31'd0, addr_ok}, 32'd1);
    cyc();
    req = 0; arready = 1; rv_en = 1;
    for (int i = 0; i < 6; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      resetn  = ($urandom_range(99) != 0);
      req     = $urandom_range(1);
      wr      = ($urandom_range(7) == 0);
      addr    = {$urandom} & 32'hffff_fffc;
      size    = 2'($urandom_range(2));
      wstrb   = 4'($urandom);
      wdata   = $urandom;
      rresp   = 2'($urandom);
      arready = $urandom_range(1);
      rv_en   = $urandom_range(1);
      step();
    end
    resetn = 1; req = 0; arready = 1; rv_en = 1;
    for (int i = 0; i < 8; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
